// File: rtl/cell_exhaustive_checker.sv
// cell_exhaustive_checker
//   Sweeps a 2-input library cell through all four input vectors, waits a
//   fixed number of cycles for the cell's path delays to settle, samples Y
//   and compares it against the FUNC truth table. It reports the error count
//   and the first failing vector for the run.
//
// Ports
//   clk_i             clock, rising edge
//   rst_i             synchronous active-high reset
//   start_i           begin a run (accepted in IDLE only)
//   num_passes_i      number of 4-vector sweeps, latched on start
//   cut_a_o/cut_b_o   drive CUT inputs A/B
//   cut_y_i           CUT output Y
//   busy_o            run in progress (DRIVE/SETTLE/SAMPLE)
//   done_o            1-cycle pulse at end of run
//   pass_o            no mismatches in the last run
//   err_count_o       saturating mismatch count
//   first_fail_vec_o  {A,B} of the first mismatch
//   first_fail_vld_o  first_fail_vec_o is valid for this run
//
// Build option
//   CUT_XCHECK_EN  when defined, X/Z on cut_y_i counts as a mismatch.
//
// state  | meaning
// IDLE   | waiting for start; results held
// DRIVE  | apply vector idx to CUT, load settle timer
// SETTLE | settle timer counting down
// SAMPLE | compare cut_y_i with FUNC[idx], advance vector/pass
// FIN    | done pulse, pass valid
module cell_exhaustive_checker #(
  parameter logic [3:0]  FUNC          = 4'b0111,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned ITER_WIDTH    = 16,
  parameter int unsigned ERR_WIDTH     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [ITER_WIDTH-1:0] num_passes_i,
  output logic                  cut_a_o,
  output logic                  cut_b_o,
  input  logic                  cut_y_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  pass_o,
  output logic [ERR_WIDTH-1:0]  err_count_o,
  output logic [1:0]            first_fail_vec_o,
  output logic                  first_fail_vld_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_FIN
  } state_t;

  state_t                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [ITER_WIDTH-1:0] rem_q, rem_d;
  logic [7:0]            settle_q, settle_d;
  logic                  cut_a_q, cut_a_d;
  logic                  cut_b_q, cut_b_d;
  logic [ERR_WIDTH-1:0]  err_q, err_d;
  logic [1:0]            ffv_q, ffv_d;
  logic                  ffvld_q, ffvld_d;
  logic                  pass_q, pass_d;
  logic                  mismatch;

  always_comb begin
`ifdef CUT_XCHECK_EN
    mismatch = (cut_y_i !== FUNC[idx_q]);
`else
    // X/Z makes the condition unknown, so the branch is not taken.
    mismatch = 1'b0;
    if (cut_y_i != FUNC[idx_q]) mismatch = 1'b1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rem_d    = rem_q;
    settle_d = settle_q;
    cut_a_d  = cut_a_q;
    cut_b_d  = cut_b_q;
    err_d    = err_q;
    ffv_d    = ffv_q;
    ffvld_d  = ffvld_q;
    pass_d   = pass_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          rem_d   = num_passes_i;
          idx_d   = 2'd0;
          err_d   = '0;
          ffv_d   = 2'd0;
          ffvld_d = 1'b0;
          pass_d  = 1'b0;
          state_d = (num_passes_i == '0) ? S_FIN : S_DRIVE;
        end
      end
      S_DRIVE: begin
        {cut_a_d, cut_b_d} = idx_q;
        settle_d           = 8'(SETTLE_CYCLES);
        state_d            = S_SETTLE;
      end
      S_SETTLE: begin
        // Leaves on the cycle the timer reads 1, giving exactly SETTLE_CYCLES cycles here.
        settle_d = settle_q - 8'd1;
        if (settle_q <= 8'd1) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
        if (mismatch) begin
          if (err_q != '1) err_d = err_q + ERR_WIDTH'(1);
          if (!ffvld_q) begin
            ffv_d   = idx_q;
            ffvld_d = 1'b1;
          end
        end
        if (idx_q == 2'd3) begin
          idx_d = 2'd0;
          if (rem_q <= ITER_WIDTH'(1)) begin
            state_d = S_FIN;
          end else begin
            rem_d   = rem_q - ITER_WIDTH'(1);
            state_d = S_DRIVE;
          end
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_DRIVE;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Resolve pass on entry to FIN so it is already valid while done is high.
    if (state_d == S_FIN) pass_d = (err_d == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      idx_q    <= 2'd0;
      rem_q    <= '0;
      settle_q <= 8'd0;
      cut_a_q  <= 1'b0;
      cut_b_q  <= 1'b0;
      err_q    <= '0;
      ffv_q    <= 2'd0;
      ffvld_q  <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      settle_q <= settle_d;
      cut_a_q  <= cut_a_d;
      cut_b_q  <= cut_b_d;
      err_q    <= err_d;
      ffv_q    <= ffv_d;
      ffvld_q  <= ffvld_d;
      pass_q   <= pass_d;
    end
  end

  assign cut_a_o          = cut_a_q;
  assign cut_b_o          = cut_b_q;
  assign busy_o           = (state_q == S_DRIVE) || (state_q == S_SETTLE) || (state_q == S_SAMPLE);
  assign done_o           = (state_q == S_FIN);
  assign pass_o           = pass_q;
  assign err_count_o      = err_q;
  assign first_fail_vec_o = ffv_q;
  assign first_fail_vld_o = ffvld_q;

endmodule

// File: tb/tb_cell_exhaustive_checker.sv
module tb_cell_exhaustive_checker;

  localparam logic [3:0]  FUNC   = 4'b0111;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned IW     = 16;
  localparam int unsigned EW     = 8;
  localparam int          ERRMAX = (1 << EW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [IW-1:0] num_passes;
  logic          cut_a, cut_b, cut_y;
  logic          busy, done, pass;
  logic [EW-1:0] err_count;
  logic [1:0]    first_fail_vec;
  logic          first_fail_vld;

  // Behavioural CUT: Y looked up from a table indexed by {A,B}.
  logic [3:0] y_tab;
  assign cut_y = y_tab[{cut_a, cut_b}];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cell_exhaustive_checker #(
    .FUNC(FUNC), .SETTLE_CYCLES(SETTLE), .ITER_WIDTH(IW), .ERR_WIDTH(EW)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .num_passes_i(num_passes),
    .cut_a_o(cut_a), .cut_b_o(cut_b), .cut_y_i(cut_y),
    .busy_o(busy), .done_o(done), .pass_o(pass), .err_count_o(err_count),
    .first_fail_vec_o(first_fail_vec), .first_fail_vld_o(first_fail_vld)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One complete run against the reference: every pass sees the same four
  // vectors, so the raw error total is passes * (number of wrong table rows).
  task automatic run(input int n, input logic [3:0] tab, input bit poke);
    int         lat, raw, exp_err, ff, budget;
    bit         seen;
    logic [3:0] diff;
    logic       a0, b0;
    y_tab   = tab;
    diff    = tab ^ FUNC;
    raw     = n * $countones(diff);
    exp_err = (raw > ERRMAX) ? ERRMAX : raw;
    ff      = 0;
    for (int v = 3; v >= 0; v--) if (diff[v]) ff = v;
    a0      = cut_a;
    b0      = cut_b;
    budget  = 1 + n * 4 * (SETTLE + 2) + 10;

    @(negedge clk);
    num_passes = IW'(n);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start      = 1'b0;
    num_passes = IW'($urandom);
    lat        = 1;
    seen       = 1'b0;
    if (n > 0) check("busy_after_start", busy, 1);
    while (lat <= budget) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      start = poke && ($urandom_range(7) == 0);
      @(posedge clk);
      #1;
      lat++;
    end
    check("done_seen", seen, 1);
    check("done_latency", lat, 1 + n * 4 * (SETTLE + 2));
    check("busy_at_done", busy, 0);
    check("err_count", err_count, exp_err);
    check("pass", pass, (raw == 0));
    check("first_fail_vld", first_fail_vld, (raw > 0));
    check("first_fail_vec", first_fail_vec, (raw > 0) ? ff : 0);
    check("cut_a_end", cut_a, (n == 0) ? a0 : 1'b1);
    check("cut_b_end", cut_b, (n == 0) ? b0 : 1'b1);

    // Start during FIN must be ignored.
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("done_pulse_1cyc", done, 0);
    check("fin_start_ignored", busy, 0);
    @(posedge clk);
    #1;
    check("idle_after_fin", busy, 0);
    check("err_count_hold", err_count, exp_err);
    check("pass_hold", pass, (raw == 0));
  endtask

  initial begin
    int n;
    bit dseen;
    rst        = 1'b1;
    start      = 1'b0;
    num_passes = '0;
    y_tab      = FUNC;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err_count, 0);
    check("rst_cut_a", cut_a, 0);
    check("rst_cut_b", cut_b, 0);
    check("rst_ffv", first_fail_vec, 0);
    check("rst_ffvld", first_fail_vld, 0);

    // Reset together with start: reset wins.
    @(negedge clk);
    start      = 1'b1;
    num_passes = IW'(3);
    @(posedge clk);
    #1;
    check("rst_beats_start", busy, 0);
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;

    run(3, FUNC, 1'b0);        // good NAND
    run(3, 4'b1111, 1'b0);     // Y stuck-at-1
    run(100, 4'b0000, 1'b0);   // Y stuck-at-0, saturates
    run(0, FUNC, 1'b0);        // zero passes

    // Reset in the SETTLE phase of pass 2.
    y_tab = 4'b1111;
    @(negedge clk);
    num_passes = IW'(3);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (17) @(posedge clk);
    #1;
    check("midrun_busy", busy, 1);
    check("midrun_err", err_count, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", busy, 0);
    check("abort_cut_a", cut_a, 0);
    check("abort_cut_b", cut_b, 0);
    check("abort_err", err_count, 0);
    check("abort_ffvld", first_fail_vld, 0);
    @(negedge clk);
    rst   = 1'b0;
    dseen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) dseen = 1'b1;
    end
    check("abort_no_done", dseen, 0);
    run(3, FUNC, 1'b0);

    // Randomized runs, including start pulses while busy.
    for (int i = 0; i < 25; i++) begin
      n = ($urandom_range(4) == 0) ? $urandom_range(60, 90) : $urandom_range(0, 12);
      run(n, 4'($urandom), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
